// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers and flag constants for the async FIFO read/write sides
package fifo_pkg;

  // Helpers work on up to 32-bit pointers; callers zero-extend and pass the real width.
  localparam int ptr_max_w = 32;

  typedef logic empty_flag_t;
  localparam empty_flag_t empty_rst = 1'b1;

  function automatic logic [ptr_max_w-1:0] width_mask(input int width);
    logic [ptr_max_w-1:0] m;
    m = '0;
    for (int i = 0; i < ptr_max_w; i++)
      if (i < width) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [ptr_max_w-1:0] bin2gray(input logic [ptr_max_w-1:0] b, input int width);
    logic [ptr_max_w-1:0] bm;
    bm = b & width_mask(width);
    return bm ^ (bm >> 1);
  endfunction

  function automatic logic [ptr_max_w-1:0] gray2bin(input logic [ptr_max_w-1:0] g, input int width);
    logic [ptr_max_w-1:0] gm;
    logic [ptr_max_w-1:0] b;
    gm = g & width_mask(width);
    b  = '0;
    for (int i = 0; i < ptr_max_w; i++)
      b[i] = ^(gm >> i);
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync2.sv
// rtl/fifo_sync2.sv - two-flop synchroniser for a Gray pointer crossing clock domains
module fifo_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/fifo_read_empty.sv
// rtl/fifo_read_empty.sv - read pointer, RAM read address and registered empty flag
// Optional almost-empty output enabled by defining FIFO_READ_AEMPTY_EN.
module fifo_read_empty
  import fifo_pkg::*;
#(
  parameter int size = 8
`ifdef FIFO_READ_AEMPTY_EN
  , parameter int AEMPTY_THR = 2
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rinc,
  input  logic [size-1:0] wptr,
  output logic [size-2:0] radr,
  output logic [size-1:0] rptr,
  output logic            rempty,
  output logic [size-1:0] rq2_wptr
`ifdef FIFO_READ_AEMPTY_EN
  , output logic          raempty
`endif
);

  logic [size-1:0] rbin;
  logic [size-1:0] rbin_next;
  logic [size-1:0] rgray_next;

  fifo_sync2 #(.W(size)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wptr),
    .q     (rq2_wptr)
  );

  // A read while empty is dropped here, so the pointer can never pass the write pointer.
  assign rbin_next  = rbin + {{(size-1){1'b0}}, rinc & ~rempty};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign radr       = rbin[size-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= empty_rst;
    end else begin
      rbin   <= rbin_next;
      rptr   <= rgray_next;
      rempty <= (rgray_next == rq2_wptr);
    end
  end

`ifdef FIFO_READ_AEMPTY_EN
  localparam logic [ptr_max_w-1:0] cnt_mask = width_mask(size);

  logic [ptr_max_w-1:0] wbin_sync;
  logic [ptr_max_w-1:0] rcount;

  // Occupancy seen from the read side, modulo the pointer range.
  assign wbin_sync = gray2bin(ptr_max_w'(rq2_wptr), size);
  assign rcount    = (wbin_sync - ptr_max_w'(rbin_next)) & cnt_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raempty <= empty_rst;
    else        raempty <= (rcount <= ptr_max_w'(AEMPTY_THR));
  end
`endif

endmodule
